ubtb_upd_ctrl: RTL

Update scheduler for the micro-BTB write port. It accepts branch-resolution updates from two requesters (resolve ports 0 and 1) and arbitrates them round-robin into a small in-order queue. It drains one update per cycle onto the uBTB `i_ubtb_update`/`i_pc_jumpsrc`/`i_pc_jumpdst` inputs, and holds back any write whose index collides with the fetch lookup in the same cycle, with a bound on how long that hold can last.

---
 rtl/ubtb_upd_ctrl_if.sv | 40 ++++
 rtl/ubtb_upd_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ubtb_upd_ctrl_if.sv
// Port bundle for the uBTB update scheduler: two resolve requesters, fetch lookup,
// flush, and the uBTB write port with the queue occupancy.
interface ubtb_upd_ctrl_if #(
  parameter int unsigned MXLEN = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             i_req0_valid;
  logic [MXLEN-1:0] i_req0_src;
  logic [MXLEN-1:0] i_req0_dst;
  logic             o_req0_ready;
  logic             i_req1_valid;
  logic [MXLEN-1:0] i_req1_src;
  logic [MXLEN-1:0] i_req1_dst;
  logic             o_req1_ready;
  logic             i_fetch_valid;
  logic [MXLEN-1:0] i_fetch_pc;
  logic             i_flush;
  logic             o_ubtb_update;
  logic [MXLEN-1:0] o_pc_jumpsrc;
  logic [MXLEN-1:0] o_pc_jumpdst;
  logic [CW-1:0]    o_count;

  modport slave (
    input  i_req0_valid, i_req0_src, i_req0_dst,
    input  i_req1_valid, i_req1_src, i_req1_dst,
    input  i_fetch_valid, i_fetch_pc, i_flush,
    output o_req0_ready, o_req1_ready,
    output o_ubtb_update, o_pc_jumpsrc, o_pc_jumpdst, o_count
  );

  modport master (
    output i_req0_valid, i_req0_src, i_req0_dst,
    output i_req1_valid, i_req1_src, i_req1_dst,
    output i_fetch_valid, i_fetch_pc, i_flush,
    input  o_req0_ready, o_req1_ready,
    input  o_ubtb_update, o_pc_jumpsrc, o_pc_jumpdst, o_count
  );
endinterface

// File: rtl/ubtb_upd_ctrl.sv
// uBTB update scheduler: round-robin merge of two resolve ports into an in-order
// queue, drained one write per cycle with a bounded hold on fetch-index collisions.
module ubtb_upd_ctrl #(
  parameter int unsigned MXLEN     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IDX_LEN   = 4,
  parameter int unsigned IDX_LSB   = 2,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  ubtb_upd_ctrl_if.slave   bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(MAX_STALL + 1);
  localparam logic [MXLEN-1:0] IDX_MASK =
    MXLEN'(((64'd1 << IDX_LEN) - 64'd1) << IDX_LSB);

  typedef struct packed {
    logic [MXLEN-1:0] src;
    logic [MXLEN-1:0] dst;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic             rr_q, rr_d;

  logic [CW-1:0]    free_c;
  logic             ready0_c, ready1_c, push0_c, push1_c;
  logic             empty_c, blocked_c, issue_c;
  entry_t           head_c;
  logic [MXLEN-1:0] fetch_nxt_c;

  // Acceptance from registered occupancy only; a same-cycle pop frees nothing.
  always_comb begin
    free_c   = CW'(DEPTH) - count_q;
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    rr_d     = rr_q;
    if (i_rstn && !bus.i_flush) begin
      if (free_c >= CW'(2)) begin
        ready0_c = bus.i_req0_valid;
        ready1_c = bus.i_req1_valid;
      end else if (free_c == CW'(1)) begin
        if (bus.i_req0_valid && bus.i_req1_valid) begin
          ready0_c = ~rr_q;
          ready1_c = rr_q;
          rr_d     = ~rr_q;
        end else begin
          ready0_c = bus.i_req0_valid;
          ready1_c = bus.i_req1_valid;
        end
      end
    end
  end

  // Head hazard against the fetch line and its sequential successor.
  always_comb begin
    head_c      = mem_q[rd_ptr_q];
    empty_c     = (count_q == '0);
    fetch_nxt_c = bus.i_fetch_pc + MXLEN'(4);
    blocked_c   = bus.i_fetch_valid &&
                  ((((head_c.src ^ bus.i_fetch_pc) & IDX_MASK) == '0) ||
                   (((head_c.src ^ fetch_nxt_c)    & IDX_MASK) == '0));
    issue_c     = !empty_c && !bus.i_flush &&
                  (!blocked_c || (stall_q == SW'(MAX_STALL)));
    push0_c     = bus.i_req0_valid && ready0_c;
    push1_c     = bus.i_req1_valid && ready1_c;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(issue_c);
    wr_ptr_d = wr_ptr_q + PW'(push0_c) + PW'(push1_c);
    count_d  = count_q + CW'(push0_c) + CW'(push1_c) - CW'(issue_c);
    stall_d  = stall_q;
    if (empty_c || issue_c) begin
      stall_d = '0;
    end else if (blocked_c && (stall_q != SW'(MAX_STALL))) begin
      stall_d = stall_q + SW'(1);
    end
    if (bus.i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      stall_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      rr_q     <= rr_d;
    end
  end

  // Payload storage; req0 lands ahead of req1 when both are taken.
  always_ff @(posedge i_clk) begin
    if (push0_c) begin
      mem_q[wr_ptr_q] <= '{src: bus.i_req0_src, dst: bus.i_req0_dst};
    end
    if (push1_c) begin
      mem_q[wr_ptr_q + PW'(push0_c)] <= '{src: bus.i_req1_src, dst: bus.i_req1_dst};
    end
  end

  assign bus.o_req0_ready  = ready0_c;
  assign bus.o_req1_ready  = ready1_c;
  assign bus.o_ubtb_update = issue_c;
  assign bus.o_pc_jumpsrc  = issue_c ? head_c.src : '0;
  assign bus.o_pc_jumpdst  = issue_c ? head_c.dst : '0;
  assign bus.o_count       = count_q;

endmodule
